// File: rtl/isqrt_pipe_arbiter.sv
// Round-robin front end for a shared fixed-latency pipelined isqrt; a circular tag buffer
// routes each result back to its requester. Define ISQRT_PIPE_ARBITER_CHECK_EN for the err check.
module isqrt_pipe_arbiter #(
  parameter int ISQRT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_vld,
  input  logic [31:0] a_x,
  input  logic        b_vld,
  input  logic [31:0] b_x,
  output logic        a_rdy,
  output logic        b_rdy,
  output logic        isqrt_x_vld,
  output logic [31:0] isqrt_x,
  input  logic        isqrt_y_vld,
  input  logic [15:0] isqrt_y,
  output logic        a_res_vld,
  output logic        b_res_vld,
  output logic [15:0] res,
  output logic        err
);
  localparam int PW = (ISQRT_LATENCY > 1) ? $clog2(ISQRT_LATENCY) : 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(ISQRT_LATENCY - 1);

  logic                     prio_q, prio_d;   // 1: B wins a tie
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [ISQRT_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ISQRT_LATENCY-1:0] tag_id_q, tag_id_d;
  logic                     a_res_vld_q, a_res_vld_d;
  logic                     b_res_vld_q, b_res_vld_d;
  logic [15:0]              res_q, res_d;
  logic                     gnt_a, gnt_b, rd_vld, rd_id, hit;

  always_comb begin
    gnt_a       = rst & a_vld & (~b_vld | ~prio_q);
    gnt_b       = rst & b_vld & (~a_vld | prio_q);
    isqrt_x_vld = gnt_a | gnt_b;
    isqrt_x     = gnt_b ? b_x : (gnt_a ? a_x : 32'd0);

    prio_d = prio_q;
    if (gnt_a)      prio_d = 1'b1;
    else if (gnt_b) prio_d = 1'b0;

    // The slot under the pointer was written exactly ISQRT_LATENCY cycles ago:
    // read it for the arriving result, then reuse it for this cycle's issue.
    rd_vld = tag_vld_q[ptr_q];
    rd_id  = tag_id_q[ptr_q];
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    tag_vld_d[ptr_q] = isqrt_x_vld;
    tag_id_d[ptr_q]  = gnt_b;
    ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;

    hit         = isqrt_y_vld & rd_vld;
    a_res_vld_d = hit & ~rd_id;
    b_res_vld_d = hit & rd_id;
    res_d       = hit ? isqrt_y : res_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= 1'b0;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      a_res_vld_q <= 1'b0;
      b_res_vld_q <= 1'b0;
      res_q       <= 16'd0;
    end else begin
      prio_q      <= prio_d;
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      a_res_vld_q <= a_res_vld_d;
      b_res_vld_q <= b_res_vld_d;
      res_q       <= res_d;
    end
  end

  assign a_rdy     = gnt_a;
  assign b_rdy     = gnt_b;
  assign a_res_vld = a_res_vld_q;
  assign b_res_vld = b_res_vld_q;
  assign res       = res_q;

`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
  logic err_q, err_d;

  // Sticky: a result with no matching issue, or an issue whose result never came.
  always_comb err_d = err_q | (isqrt_y_vld ^ rd_vld);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Bench for isqrt_pipe_arbiter: two instances (latency 4 and 7) share one stimulus, each fed by
// a behavioural isqrt pipe, checked against a grant/queue reference model plus directed tables.
module tb_isqrt_pipe_arbiter;
  localparam int L0 = 4;
  localparam int L1 = 7;
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst, a_vld, b_vld, force_y;
  logic [31:0] a_x, b_x;
  logic        a_rdy_o[2], b_rdy_o[2], xvld_o[2], a_res_o[2], b_res_o[2], err_o[2];
  logic [31:0] x_o[2];
  logic [15:0] res_o[2];
  logic        y_vld_i[2];
  logic [15:0] y_i[2];

  isqrt_pipe_arbiter u4 (
    .clk(clk), .rst(rst), .a_vld(a_vld), .a_x(a_x), .b_vld(b_vld), .b_x(b_x),
    .a_rdy(a_rdy_o[0]), .b_rdy(b_rdy_o[0]), .isqrt_x_vld(xvld_o[0]), .isqrt_x(x_o[0]),
    .isqrt_y_vld(y_vld_i[0]), .isqrt_y(y_i[0]), .a_res_vld(a_res_o[0]), .b_res_vld(b_res_o[0]),
    .res(res_o[0]), .err(err_o[0]));

  isqrt_pipe_arbiter #(.ISQRT_LATENCY(L1)) u7 (
    .clk(clk), .rst(rst), .a_vld(a_vld), .a_x(a_x), .b_vld(b_vld), .b_x(b_x),
    .a_rdy(a_rdy_o[1]), .b_rdy(b_rdy_o[1]), .isqrt_x_vld(xvld_o[1]), .isqrt_x(x_o[1]),
    .isqrt_y_vld(y_vld_i[1]), .isqrt_y(y_i[1]), .a_res_vld(a_res_o[1]), .b_res_vld(b_res_o[1]),
    .res(res_o[1]), .err(err_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] isqrt_f(input logic [31:0] x);
    longint r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[15:0];
  endfunction

  // Shared isqrt unit models: fixed-latency pipes, cleared by the common reset.
  logic        pv[2][8];
  logic [15:0] py[2][8];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 8; i++) begin pv[k][i] <= 1'b0; py[k][i] <= 16'd0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 7; i > 0; i--) begin pv[k][i] <= pv[k][i-1]; py[k][i] <= py[k][i-1]; end
        pv[k][0] <= xvld_o[k];
        py[k][0] <= isqrt_f(x_o[k]);
      end
    end
  end
  assign y_vld_i[0] = pv[0][L0-1] | force_y;
  assign y_i[0]     = py[0][L0-1];
  assign y_vld_i[1] = pv[1][L1-1];
  assign y_i[1]     = py[1][L1-1];

  // Reference model: round-robin grant and in-order expected results per instance.
  typedef struct { bit id; logic [15:0] val; int due; } exp_t;
  exp_t        q0[$], q1[$], f;
  bit          last_b = 1'b1, ga, gb, pe;
  logic [15:0] last_res[2];
  bit          err_exp[2];
  int          nissue = 0;
  int          nres[2];

  initial begin
    nres[0] = 0; nres[1] = 0; last_res[0] = 0; last_res[1] = 0; err_exp[0] = 0; err_exp[1] = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_a_rdy", k, a_rdy_o[k], 0);
        chk("rst_b_rdy", k, b_rdy_o[k], 0);
        chk("rst_res_vld", k, {a_res_o[k], b_res_o[k]}, 0);
        chk("rst_res", k, res_o[k], 0);
        chk("rst_err", k, err_o[k], 0);
        last_res[k] = 0;
        err_exp[k] = 0;
      end
      q0.delete(); q1.delete();
      last_b = 1'b1;
    end else begin
      ga = a_vld && (!b_vld || last_b);
      gb = b_vld && !ga;
      for (int k = 0; k < 2; k++) begin
        chk("a_rdy", k, a_rdy_o[k], ga);
        chk("b_rdy", k, b_rdy_o[k], gb);
        chk("isqrt_x_vld", k, xvld_o[k], ga | gb);
        if (ga | gb) chk("isqrt_x", k, x_o[k], ga ? a_x : b_x);
      end
      if (ga | gb) begin
        q0.push_back('{gb, isqrt_f(ga ? a_x : b_x), cyc + L0 + 1});
        q1.push_back('{gb, isqrt_f(ga ? a_x : b_x), cyc + L1 + 1});
        last_b = gb;
        nissue++;
      end
      for (int k = 0; k < 2; k++) begin
        pe = 1'b0;
        f = '{1'b0, 16'd0, 0};
        if (k == 0 && q0.size() != 0 && q0[0].due == cyc) begin f = q0.pop_front(); pe = 1'b1; end
        if (k == 1 && q1.size() != 0 && q1[0].due == cyc) begin f = q1.pop_front(); pe = 1'b1; end
        chk("a_res_vld", k, a_res_o[k], pe && !f.id);
        chk("b_res_vld", k, b_res_o[k], pe && f.id);
        if (pe) last_res[k] = f.val;
        chk("res", k, res_o[k], last_res[k]);
        chk("err", k, err_o[k], err_exp[k]);
        if (a_res_o[k] | b_res_o[k]) nres[k]++;
      end
      if (force_y) err_exp[0] = CHK;
    end
  end

  typedef struct {
    logic av; logic [31:0] ax; logic bv; logic [31:0] bx; logic ea; logic eb; logic [15:0] eres;
  } vec_t;
  vec_t tbl[4];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0; a_vld = 1'b1; b_vld = 1'b1; a_x = 32'd7; b_x = 32'd8;
    @(negedge clk);
    chk("rdy_in_rst", 0, {a_rdy_o[0], b_rdy_o[0]}, 0);
    step();
    a_vld = 1'b0; b_vld = 1'b0;
    step();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rnd_x();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 300));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_drive(input int n, input int pct, input bit cont);
    bit acc_a, acc_b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc_a = a_vld & a_rdy_o[0];
      acc_b = b_vld & b_rdy_o[0];
      step();
      if (!a_vld || acc_a) begin a_vld = ($urandom_range(0, 99) < pct); a_x = rnd_x(); end
      if (!b_vld || acc_b) begin b_vld = ($urandom_range(0, 99) < pct); b_x = rnd_x(); end
      if (cont && !a_vld && !b_vld) begin a_vld = 1'b1; a_x = rnd_x(); end
    end
    @(negedge clk);
    step();
    a_vld = 1'b0; b_vld = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int s, n0, r0, r1;
  initial begin
    tbl[0] = '{1'b1, 32'd1,  1'b1, 32'd4,  1'b1, 1'b0, 16'd1};
    tbl[1] = '{1'b1, 32'd9,  1'b1, 32'd4,  1'b0, 1'b1, 16'd2};
    tbl[2] = '{1'b1, 32'd9,  1'b1, 32'd16, 1'b1, 1'b0, 16'd3};
    tbl[3] = '{1'b1, 32'd25, 1'b1, 32'd16, 1'b0, 1'b1, 16'd4};
    rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; a_x = 0; b_x = 0; force_y = 1'b0;
    #1 rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;

    // A alone: x=144 at cycle 10 -> a_res_vld at cycle 15 with 12
    wait_cyc(10);
    a_vld = 1'b1; a_x = 32'd144;
    step();
    a_vld = 1'b0;
    wait_cyc(15);
    @(negedge clk);
    chk("a144_vld", 0, a_res_o[0], 1);
    chk("a144_res", 0, res_o[0], 12);
    chk("a144_b", 0, b_res_o[0], 0);
    wait_cyc(25);

    // Both valid: alternating grants and routing of results
    do_reset();
    s = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      step();
      a_vld = tbl[i].av; a_x = tbl[i].ax; b_vld = tbl[i].bv; b_x = tbl[i].bx;
      @(negedge clk);
      chk("tbl_a_rdy", i, a_rdy_o[0], tbl[i].ea);
      chk("tbl_b_rdy", i, b_rdy_o[0], tbl[i].eb);
    end
    step();
    a_vld = 1'b0; b_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(s + i + L0 + 1);
      @(negedge clk);
      chk("tbl_a_res", i, a_res_o[0], tbl[i].ea);
      chk("tbl_b_res", i, b_res_o[0], tbl[i].eb);
      chk("tbl_res", i, res_o[0], tbl[i].eres);
    end
    repeat (10) step();

    // Max operand
    b_vld = 1'b1; b_x = 32'hFFFF_FFFF;
    s = cyc;
    step();
    b_vld = 1'b0;
    wait_cyc(s + L0 + 1);
    @(negedge clk);
    chk("max_b_vld", 0, b_res_o[0], 1);
    chk("max_res", 0, res_o[0], 65535);
    repeat (10) step();

    // Continuous issue: 100 back-to-back issues, all results on the latency-7 instance
    n0 = nissue; r1 = nres[1];
    rand_drive(100, 60, 1'b1);
    chk("no_bubble", 1, nissue - n0, 100);
    repeat (12) step();
    chk("cont_results", 1, nres[1] - r1, 100);

    // Random traffic with gaps
    rand_drive(200, 40, 1'b0);
    repeat (12) step();

    // Reset two cycles after issuing 81: result dropped
    r0 = nres[0]; r1 = nres[1];
    a_vld = 1'b1; a_x = 32'd81;
    step();
    a_vld = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("rst81_drop4", 0, nres[0] - r0, 0);
    chk("rst81_drop7", 1, nres[1] - r1, 0);
    chk("rst81_err", 0, err_o[0], 0);

    // Spurious result with no issue
    r0 = nres[0];
    force_y = 1'b1;
    step();
    force_y = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("spur_err", 0, err_o[0], CHK);
    chk("spur_drop", 0, nres[0] - r0, 0);
    do_reset();
    @(negedge clk);
    chk("spur_err_clr", 0, err_o[0], 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
